// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_arbiter_if : requester-side and RAM-side signal bundle for ram_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        wen;
  logic [NREQ-1:0]        lock;
  logic [NREQ-1:0][31:0]  addr;
  logic [NREQ-1:0][31:0]  wdata;
  logic [NREQ-1:0]        rwait;
  logic [NREQ-1:0][31:0]  rdata;
  logic [NREQ-1:0]        grant;
  logic                   ramREN;
  logic                   ramWEN;
  logic [31:0]            ramaddr;
  logic [31:0]            ramstore;
  logic [31:0]            ramload;
  logic [1:0]             ramstate;

  modport slave (
    input  req, wen, lock, addr, wdata, ramload, ramstate,
    output rwait, rdata, grant, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output req, wen, lock, addr, wdata, ramload, ramstate,
    input  rwait, rdata, grant, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_arbiter : round-robin arbiter sharing one RAM port among NREQ requesters
// Rev 1.0
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int NREQ     = 2,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  localparam int         OW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int         CW         = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e        fsm_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;

  logic          w_win_vld;
  logic [OW-1:0] w_win;
  logic [OW-1:0] w_next_ptr;
  logic          w_req_own;
  logic          w_lock_own;
  logic          w_done;

  // First requesting index when scanning upward from ptr_q, wrapping at NREQ.
  always_comb begin
    int            idx;
    logic [OW-1:0] cand;
    w_win_vld = 1'b0;
    w_win     = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = OW'(idx);
      if (!w_win_vld && bus.req[cand]) begin
        w_win_vld = 1'b1;
        w_win     = cand;
      end
    end
  end

  assign w_next_ptr = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
  assign w_req_own  = bus.req[owner_q];
  assign w_lock_own = bus.lock[owner_q];
  assign w_done     = (fsm_q == SERVE) && w_req_own && (bus.ramstate == RAM_ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (w_win_vld) begin
            owner_q <= w_win;
            fsm_q   <= SERVE;
            cnt_q   <= '0;
          end
        end
        SERVE: begin
          // A locked owner keeps the port until MAX_LOCK words have completed.
          if (w_done && w_lock_own && (int'(cnt_q) < MAX_LOCK - 1)) begin
            cnt_q <= cnt_q + CW'(1);
          end else if (w_done || (!w_req_own && !w_lock_own)) begin
            fsm_q <= IDLE;
            ptr_q <= w_next_ptr;
            cnt_q <= '0;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them without a clock.
  always_comb begin
    bus.rwait    = '1;
    bus.rdata    = '0;
    bus.grant    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (fsm_q == SERVE) begin
      bus.grant[owner_q] = 1'b1;
      bus.ramaddr        = bus.addr[owner_q];
      bus.ramstore       = bus.wdata[owner_q];
      bus.ramREN         = w_req_own & ~bus.wen[owner_q];
      bus.ramWEN         = w_req_own & bus.wen[owner_q];
      bus.rdata[owner_q] = bus.ramload;
      if (w_done) bus.rwait[owner_q] = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ram_arbiter : directed and randomized checks of ram_arbiter against a model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ram_arbiter;
  localparam int         NREQ      = 2;
  localparam int         MAX_LOCK  = 4;
  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.NREQ(NREQ)) bus ();
  ram_arbiter #(.NREQ(NREQ), .MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Reference model: current owner (-1 = nobody), round-robin start, words under lock.
  int m_own = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  int          n_left [NREQ];
  bit          lock_mode [NREQ];
  bit          rand_mode = 1'b0;
  int          cyc = 0;
  int          t0 = 0;
  int          first_gcyc = -1;
  logic [1:0]  first_grant = '0;
  int          comp_log [$];
  int          comp_cyc [$];
  logic [31:0] comp_dat [$];

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += n_left[i];
    return s;
  endfunction

  task automatic new_word(input int i);
    bus.addr[i]  = $urandom & 32'hFFFF_FFFC;
    bus.wdata[i] = $urandom;
    bus.wen[i]   = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_script();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]  = (n_left[i] > 0);
      bus.lock[i] = lock_mode[i] && (n_left[i] > 1);
    end
  endtask

  task automatic start_test();
    comp_log.delete();
    comp_cyc.delete();
    comp_dat.delete();
    t0         = cyc;
    first_gcyc = -1;
    first_grant = '0;
  endtask

  task automatic cycle();
    logic [NREQ-1:0] e_grant, e_rwait;
    logic [63:0]     e_rdata;
    logic            e_ren, e_wen;
    logic [31:0]     e_addr, e_store;
    logic [63:0]     rd;
    int              o;
    bit              comp;
    int              r;
    @(negedge clk);
    e_grant = '0; e_rwait = '1; e_rdata = '0; e_ren = 1'b0; e_wen = 1'b0;
    e_addr = '0; e_store = '0; comp = 1'b0;
    o = m_own;
    if (o >= 0) begin
      e_grant[o]          = 1'b1;
      e_addr              = bus.addr[o];
      e_store             = bus.wdata[o];
      e_ren               = bus.req[o] & ~bus.wen[o];
      e_wen               = bus.req[o] & bus.wen[o];
      e_rdata[o*32 +: 32] = bus.ramload;
      comp                = bus.req[o] && (bus.ramstate == ST_ACCESS);
      if (comp) e_rwait[o] = 1'b0;
    end
    check_eq("grant", 64'(bus.grant), 64'(e_grant));
    check_eq("rwait", 64'(bus.rwait), 64'(e_rwait));
    check_eq("rdata", 64'(bus.rdata), e_rdata);
    check_eq("ramREN", 64'(bus.ramREN), 64'(e_ren));
    check_eq("ramWEN", 64'(bus.ramWEN), 64'(e_wen));
    check_eq("ramaddr", 64'(bus.ramaddr), 64'(e_addr));
    check_eq("ramstore", 64'(bus.ramstore), 64'(e_store));
    rd = bus.rdata;
    for (int i = 0; i < NREQ; i++) begin
      if (!bus.rwait[i]) begin
        comp_log.push_back(i);
        comp_cyc.push_back(cyc - t0);
        comp_dat.push_back(rd[i*32 +: 32]);
      end
    end
    if (bus.grant != '0 && first_gcyc < 0) begin
      first_gcyc  = cyc - t0;
      first_grant = bus.grant;
    end
    @(posedge clk);
    if (o < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_own < 0 && bus.req[(m_ptr + k) % NREQ]) begin
          m_own = (m_ptr + k) % NREQ;
          m_cnt = 0;
        end
      end
    end else if (comp) begin
      if (bus.lock[o] && m_cnt < MAX_LOCK - 1) m_cnt++;
      else begin m_own = -1; m_ptr = (o + 1) % NREQ; m_cnt = 0; end
    end else if (!bus.req[o] && !bus.lock[o]) begin
      m_own = -1; m_ptr = (o + 1) % NREQ; m_cnt = 0;
    end
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (rand_mode) begin
        if (comp && o == i) begin
          bus.req[i]  = ($urandom_range(0, 2) != 0);
          bus.lock[i] = 1'($urandom_range(0, 1));
          new_word(i);
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 2) == 0) begin bus.req[i] = 1'b1; new_word(i); end
        end else if ($urandom_range(0, 40) == 0) begin
          bus.req[i] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) bus.lock[i] = ~bus.lock[i];
      end else begin
        if (comp && o == i) begin
          n_left[i]--;
          bus.addr[i] = bus.addr[i] + 32'd4;
        end
      end
    end
    if (rand_mode) begin
      r = $urandom_range(0, 9);
      bus.ramstate = (r < 4) ? ST_ACCESS : 2'(r);
      bus.ramload  = $urandom;
    end else begin
      apply_script();
    end
  endtask

  task automatic run_script(input int maxc);
    int n = 0;
    apply_script();
    while ((pending() > 0 || m_own >= 0) && n < maxc) begin
      cycle();
      n++;
    end
    check_eq("run_timeout", 64'(pending() > 0 || m_own >= 0), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      n_left[i] = 0; lock_mode[i] = 1'b0;
      bus.addr[i] = 32'h0; bus.wdata[i] = 32'h0;
    end
    bus.req = '1; bus.wen = '0; bus.lock = '0;
    bus.ramload = 32'h0; bus.ramstate = ST_ACCESS;

    // Outputs held at reset values even with every request raised.
    #12;
    check_eq("rst_grant", 64'(bus.grant), 64'd0);
    check_eq("rst_rwait", 64'(bus.rwait), 64'h3);
    check_eq("rst_ren", 64'(bus.ramREN), 64'd0);
    check_eq("rst_addr", 64'(bus.ramaddr), 64'd0);
    check_eq("rst_rdata", 64'(bus.rdata), 64'd0);
    bus.req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single read, RAM latency 2
    start_test();
    n_left[0] = 1; bus.addr[0] = 32'h40; bus.wen[0] = 1'b0; bus.ramload = 32'h1234;
    apply_script();
    bus.ramstate = ST_FREE;   cycle();
    bus.ramstate = ST_BUSY;   cycle(); cycle();
    bus.ramstate = ST_ACCESS; cycle();
    check_eq("t1_cycle", 64'(comp_cyc[0]), 64'd3);
    check_eq("t1_rdata", 64'(comp_dat[0]), 64'h1234);

    // Write from requester 1
    start_test();
    n_left[1] = 1; bus.addr[1] = 32'h80; bus.wdata[1] = 32'hDEADBEEF; bus.wen[1] = 1'b1;
    run_script(20);
    check_eq("t2_grant", 64'(first_grant), 64'h2);
    check_eq("t2_who", 64'(comp_log[0]), 64'd1);
    bus.wen[1] = 1'b0;

    // Simultaneous requests: 0 first, one idle cycle, then 1
    start_test();
    n_left[0] = 1; n_left[1] = 1;
    run_script(20);
    check_eq("t3_first", 64'(comp_log[0]), 64'd0);
    check_eq("t3_second", 64'(comp_log[1]), 64'd1);
    check_eq("t3_gap", 64'(comp_cyc[1] - comp_cyc[0]), 64'd2);

    // Locked two-word burst with requester 1 waiting
    start_test();
    n_left[0] = 2; lock_mode[0] = 1'b1; bus.addr[0] = 32'h100; n_left[1] = 1;
    run_script(20);
    check_eq("t4_b2b", 64'(comp_cyc[1] - comp_cyc[0]), 64'd1);
    check_eq("t4_w0", 64'(comp_log[0]), 64'd0);
    check_eq("t4_w1", 64'(comp_log[1]), 64'd0);
    check_eq("t4_w2", 64'(comp_log[2]), 64'd1);

    // Lock held for 6 words: forced release after MAX_LOCK
    start_test();
    n_left[0] = 6; n_left[1] = 1;
    run_script(40);
    begin
      int exp_log [7] = '{0, 0, 0, 0, 1, 0, 0};
      check_eq("t5_len", 64'(comp_log.size()), 64'd7);
      for (int k = 0; k < 7; k++) check_eq($sformatf("t5_log%0d", k), 64'(comp_log[k]), 64'(exp_log[k]));
    end
    lock_mode[0] = 1'b0;

    // Asynchronous reset while a read is in flight
    start_test();
    n_left[0] = 1; bus.ramstate = ST_BUSY;
    apply_script();
    cycle(); cycle();
    #2;
    check_eq("t6_pre_ren", 64'(bus.ramREN), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_grant", 64'(bus.grant), 64'd0);
    check_eq("t6_ren", 64'(bus.ramREN), 64'd0);
    check_eq("t6_rwait", 64'(bus.rwait), 64'h3);
    m_own = -1; m_ptr = 0; m_cnt = 0;
    n_left[0] = 0;
    apply_script();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.ramstate = ST_ACCESS;
    start_test();
    n_left[0] = 1; n_left[1] = 1;
    run_script(20);
    check_eq("t6_arb_lat", 64'(first_gcyc), 64'd1);
    check_eq("t6_ptr0", 64'(comp_log[0]), 64'd0);

    // Randomized traffic against the model
    rand_mode = 1'b1;
    for (int i = 0; i < NREQ; i++) begin bus.req[i] = 1'b1; new_word(i); end
    repeat (1500) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
